bf_result_streamer: RTL and testbench

- Downstream stage of the Bellman-Ford engine; consumes the output memory after the engine raises Finish or NegCycle.
- Walks output memory from address 0 to NUM_NODES-1 and streams each distance over a valid/ready interface with its node index.
- NegCycle is reported as a single flagged beat.
- Replaces the bench's dump loop for the on-chip result path; owns the output memory read port (OMAR/OMDR) once the engine has finished.

---
 rtl/bf_pkg.sv | 31 +++
 rtl/bf_result_streamer_if.sv | 29 ++
 rtl/bf_edge_det.sv | 33 +++
 rtl/bf_result_streamer.sv | 188 ++++++++++++++++++
 tb/tb_bf_result_streamer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_pkg
// Description : Shared constants and types for the Bellman-Ford result path:
//               memory/distance widths, the unreachable-distance encoding,
//               the streamer state enum and the stream beat record.
// Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] INF_VAL = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        HOLD  = 3'd2,
        NEG   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
        logic              neg;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/bf_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : bf_result_streamer_if
// Description : Valid/ready result stream carrying one distance per beat
//               with its node index, last marker and negative-cycle flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface bf_result_streamer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              out_neg;

    modport master (
        output out_valid, out_data, out_index, out_last, out_neg,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last, out_neg,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/bf_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : bf_edge_det
// Description : Single-bit rising-edge detector with synchronous reset.
//               The detector is disarmed for the first cycle after reset so
//               a level that is already high at release is not seen as a rise.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_edge_det (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_din,
    output logic      o_rise
);

    logic r_prev;
    logic r_armed;

    // Track the previous input level and arm one cycle after reset release.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_din;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = r_armed & i_din & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/bf_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : bf_result_streamer
// Description : Walks the Bellman-Ford output memory from address 0 to
//               NUM_NODES-1 after Finish rises and streams each distance with
//               its node index; a NegCycle rise yields one flagged beat.
//               Optional statistics (reach_cnt, max_dist) are built only when
//               the RESULT_STATS_EN macro is defined; otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_result_streamer #(
    parameter int                ADDR_W    = bf_pkg::ADDR_W,
    parameter int                DATA_W    = bf_pkg::DATA_W,
    parameter int                NUM_NODES = 8192,
    parameter logic [DATA_W-1:0] INF_VAL   = bf_pkg::INF_VAL
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              Finish,
    input  wire logic              NegCycle,
    output logic [ADDR_W-1:0]      OMAR,
    input  wire logic [DATA_W-1:0] OMDR,
    bf_result_streamer_if.master   strm,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        reach_cnt,
    output logic [DATA_W-1:0]      max_dist
);
    import bf_pkg::*;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_NODES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_fin_rise;
    logic              w_neg_rise;
    logic              w_start;
    logic              w_load;
    logic              w_neg_load;
    logic              w_accept;

    logic [ADDR_W-1:0] r_omar;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_out_last;
    logic              r_out_neg;
    logic              r_busy;
    logic              r_done;

    bf_edge_det u_fin_edge (
        .clock  (clock),
        .reset  (reset),
        .i_din  (Finish),
        .o_rise (w_fin_rise)
    );

    bf_edge_det u_neg_edge (
        .clock  (clock),
        .reset  (reset),
        .i_din  (NegCycle),
        .o_rise (w_neg_rise)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes; NegCycle wins a tie in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_neg_load  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_neg_rise) begin
                    w_neg_load  = 1'b1;
                    w_state_nxt = NEG;
                end else if (w_fin_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_load      = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (strm.out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = r_out_last ? DONE : FETCH;
                end
            end
            NEG: begin
                if (strm.out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read address, beat register and status flags driven by the FSM strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_omar      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_neg   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start) begin
                r_omar <= '0;
                r_busy <= 1'b1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= OMDR;
                r_out_index <= r_omar;
                r_out_last  <= (r_omar == c_LAST_ADDR);
            end
            if (w_neg_load) begin
                r_out_valid <= 1'b1;
                r_out_neg   <= 1'b1;
                r_out_data  <= INF_VAL;
                r_out_index <= '0;
                r_out_last  <= 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                // The last beat never advances the address, so OMAR cannot wrap.
                if (r_out_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_omar <= r_omar + ADDR_W'(1);
                end
            end
        end
    end

`ifdef RESULT_STATS_EN
    logic [ADDR_W:0]   r_reach_cnt;
    logic [DATA_W-1:0] r_max_dist;

    // Accumulate reachable-node count and largest finite distance per accepted beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_reach_cnt <= '0;
            r_max_dist  <= '0;
        end else if (w_accept && !r_out_neg && (r_out_data != INF_VAL)) begin
            r_reach_cnt <= r_reach_cnt + (ADDR_W+1)'(1);
            if (r_out_data > r_max_dist) begin
                r_max_dist <= r_out_data;
            end
        end
    end

    assign reach_cnt = r_reach_cnt;
    assign max_dist  = r_max_dist;
`else
    assign reach_cnt = '0;
    assign max_dist  = '0;
`endif

    assign OMAR           = r_omar;
    assign strm.out_valid = r_out_valid;
    assign strm.out_data  = r_out_data;
    assign strm.out_index = r_out_index;
    assign strm.out_last  = r_out_last;
    assign strm.out_neg   = r_out_neg;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bf_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf_result_streamer
// Description : Scoreboard bench for bf_result_streamer. A 4-node instance
//               covers normal streaming, back-pressure, NegCycle, tie and
//               mid-stream reset; an 8192-node instance covers the full
//               address range with all-unreachable data.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bf_result_streamer;
    import bf_pkg::*;

`ifdef RESULT_STATS_EN
    localparam int c_EXP_RC = 3;
    localparam int c_EXP_MD = 5;
`else
    localparam int c_EXP_RC = 0;
    localparam int c_EXP_MD = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        fin4, neg4, busy4, done4;
    logic [12:0] omar4;
    logic [15:0] omdr4;
    logic [13:0] rc4;
    logic [15:0] md4;
    logic [15:0] mem4 [0:3];

    logic        fin8, neg8, busy8, done8;
    logic [12:0] omar8;
    logic [15:0] omdr8;
    logic [13:0] rc8;
    logic [15:0] md8;

    int checks   = 0;
    int failures = 0;

    bf_result_streamer_if #(.ADDR_W(13), .DATA_W(16)) if4 ();
    bf_result_streamer_if #(.ADDR_W(13), .DATA_W(16)) if8 ();

    assign omdr4 = mem4[omar4[1:0]];
    assign omdr8 = 16'hFFFF;

    bf_result_streamer #(.NUM_NODES(4)) u_dut4 (
        .clock     (clock),
        .reset     (reset),
        .Finish    (fin4),
        .NegCycle  (neg4),
        .OMAR      (omar4),
        .OMDR      (omdr4),
        .strm      (if4),
        .busy      (busy4),
        .done      (done4),
        .reach_cnt (rc4),
        .max_dist  (md4)
    );

    bf_result_streamer #(.NUM_NODES(8192)) u_dut8k (
        .clock     (clock),
        .reset     (reset),
        .Finish    (fin8),
        .NegCycle  (neg8),
        .OMAR      (omar8),
        .OMDR      (omdr8),
        .strm      (if8),
        .busy      (busy8),
        .done      (done8),
        .reach_cnt (rc8),
        .max_dist  (md8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the 4-node instance: every accepted beat pops one entry.
    beat_t exp_q [$];
    int    beats4 = 0;

    always @(negedge clock) begin
        if (!reset && if4.out_valid && if4.out_ready) begin
            beats4 <= beats4 + 1;
            if (exp_q.size() == 0) begin
                check_val("sb_extra_beat", {if4.out_data, if4.out_index}, 64'd0);
            end else begin
                check_val("sb_data",  if4.out_data,  exp_q[0].data);
                check_val("sb_index", if4.out_index, exp_q[0].index);
                check_val("sb_last",  if4.out_last,  exp_q[0].last);
                check_val("sb_neg",   if4.out_neg,   exp_q[0].neg);
                exp_q.delete(0);
            end
        end
    end

    // Monitor for the 8192-node instance: index sequence and address wrap.
    int          cnt8 = 0;
    logic        wrap8 = 1'b0;
    logic [12:0] prev_omar8 = '0;

    always @(negedge clock) begin
        if (!reset && if8.out_valid && if8.out_ready) begin
            check_val("beat8k", {if8.out_data, if8.out_index, if8.out_last, if8.out_neg},
                      {16'hFFFF, 13'(cnt8), (cnt8 == 8191), 1'b0});
            cnt8 <= cnt8 + 1;
        end
        if (busy8 && (omar8 < prev_omar8)) wrap8 <= 1'b1;
        prev_omar8 <= omar8;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_stream4();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: mem4[i], index: 13'(i), last: (i == 3), neg: 1'b0});
        end
    endtask

    task automatic push_neg4();
        exp_q.push_back('{data: 16'hFFFF, index: 13'd0, last: 1'b1, neg: 1'b1});
    endtask

    task automatic wait_done(input bit big, input int budget, output int cyc);
        cyc = 0;
        while (!(big ? done8 : done4) && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check_val(big ? "done8k_within_budget" : "done_within_budget",
                  big ? done8 : done4, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fin4 = 1'b0; neg4 = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        int cyc, b0, b8;
        reset = 1'b1;
        fin4 = 1'b0; neg4 = 1'b0; fin8 = 1'b0; neg8 = 1'b0;
        if4.out_ready = 1'b1;
        if8.out_ready = 1'b1;
        mem4[0] = 16'h0000; mem4[1] = 16'h0005; mem4[2] = 16'hFFFF; mem4[3] = 16'h0003;
        tick(3);

        check_val("rst_valid", if4.out_valid, 0);
        check_val("rst_data",  if4.out_data,  0);
        check_val("rst_index", if4.out_index, 0);
        check_val("rst_flags", {if4.out_last, if4.out_neg, busy4, done4}, 0);
        check_val("rst_omar",  omar4, 0);
        check_val("rst_stats", {rc4, md4}, 0);
        reset = 1'b0;
        tick(2);

        // Normal stream with the consumer always ready.
        b0 = beats4;
        push_stream4();
        fin4 = 1'b1;
        tick(1);
        check_val("t1_valid_after_1", if4.out_valid, 0);
        check_val("t1_busy", busy4, 1);
        tick(1);
        check_val("t1_first_valid", if4.out_valid, 1);
        check_val("t1_first_index", if4.out_index, 0);
        check_val("t1_first_data",  if4.out_data,  0);
        wait_done(1'b0, 40, cyc);
        check_val("t1_done_latency", cyc, 7);
        check_val("t1_beats", beats4 - b0, 4);
        check_val("t1_sb_empty", exp_q.size(), 0);
        check_val("t1_busy_end", busy4, 0);
        check_val("t1_omar_end", omar4, 3);
        check_val("t1_reach_cnt", rc4, c_EXP_RC);
        check_val("t1_max_dist",  md4, c_EXP_MD);

        // DONE is terminal: fresh edges produce nothing.
        fin4 = 1'b0; tick(2);
        fin4 = 1'b1; neg4 = 1'b1; tick(4);
        check_val("done_ignores_edges", {if4.out_valid, done4}, 2'b01);
        check_val("done_no_beats", beats4 - b0, 4);

        // Levels already high at reset release must not start a stream.
        reset = 1'b1; tick(1);
        reset = 1'b0; tick(4);
        check_val("level_at_release", {if4.out_valid, busy4, done4}, 0);
        fin4 = 1'b0; neg4 = 1'b0; tick(2);

        // Back-pressure on beat 1.
        b0 = beats4;
        push_stream4();
        fin4 = 1'b1;
        tick(3);
        if4.out_ready = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", if4.out_valid, 1);
            check_val("stall_data",  if4.out_data,  5);
            check_val("stall_index", if4.out_index, 1);
            tick(1);
        end
        if4.out_ready = 1'b1;
        wait_done(1'b0, 40, cyc);
        check_val("stall_beats", beats4 - b0, 4);
        check_val("stall_sb_empty", exp_q.size(), 0);
        do_reset();

        // NegCycle alone.
        b0 = beats4;
        push_neg4();
        neg4 = 1'b1;
        wait_done(1'b0, 20, cyc);
        check_val("neg_beats", beats4 - b0, 1);
        check_val("neg_sb_empty", exp_q.size(), 0);
        check_val("neg_omar", omar4, 0);
        check_val("neg_stats", {rc4, md4}, 0);
        do_reset();

        // Finish and NegCycle rise together: only the NEG beat.
        b0 = beats4;
        push_neg4();
        fin4 = 1'b1; neg4 = 1'b1;
        wait_done(1'b0, 20, cyc);
        tick(4);
        check_val("tie_beats", beats4 - b0, 1);
        check_val("tie_sb_empty", exp_q.size(), 0);
        check_val("tie_omar", omar4, 0);
        do_reset();

        // Reset while holding beat 2, then restart from index 0.
        b0 = beats4;
        push_stream4();
        fin4 = 1'b1;
        tick(5);
        if4.out_ready = 1'b0;
        tick(1);
        check_val("hold2_index", {if4.out_valid, if4.out_index}, {1'b1, 13'd2});
        reset = 1'b1;
        tick(1);
        check_val("abort_state", {if4.out_valid, busy4, done4}, 0);
        check_val("abort_omar", omar4, 0);
        check_val("abort_beats", beats4 - b0, 2);
        exp_q.delete();
        reset = 1'b0; fin4 = 1'b0; if4.out_ready = 1'b1;
        tick(2);
        b0 = beats4;
        push_stream4();
        fin4 = 1'b1;
        tick(2);
        check_val("restart_first", {if4.out_valid, if4.out_index}, {1'b1, 13'd0});
        wait_done(1'b0, 40, cyc);
        check_val("restart_beats", beats4 - b0, 4);
        check_val("restart_sb_empty", exp_q.size(), 0);

        // Full 8192-entry walk, all unreachable.
        b8 = cnt8;
        fin8 = 1'b1;
        wait_done(1'b1, 20000, cyc);
        tick(1);
        check_val("full_beats", cnt8 - b8, 8192);
        check_val("full_no_wrap", wrap8, 0);
        check_val("full_omar_end", omar8, 8191);
        check_val("full_stats", {rc8, md8}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
